// File: rtl/vga_pkg.sv
// Shared game-mode encoding, paddle controller states and default screen geometry.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_MULTI  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MULTI  = 2'd2
    } paddle_st_e;

    localparam int PADDLE_H_DEF       = 128;
    localparam int Y_MAX_DEF          = 768;
    localparam int STEP_DEF           = 8;
    localparam int AI_STEP_DEF        = 4;
    localparam int TIMEOUT_FRAMES_DEF = 4;
    localparam int POS_W_DEF          = 10;

    // The unused encoding 3 falls back to idle.
    function automatic paddle_st_e mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_SINGLE: return ST_SINGLE;
            MODE_MULTI:  return ST_MULTI;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/paddle_slew.sv
// Turns a centre-line request into a clamped paddle-top target and steps the
// current position toward it by at most STEP pixels.
module paddle_slew
    import vga_pkg::*;
#(
    parameter int PADDLE_H = PADDLE_H_DEF,
    parameter int Y_MAX    = Y_MAX_DEF,
    parameter int STEP     = STEP_DEF,
    parameter int POS_W    = POS_W_DEF
) (
    input  logic [11:0]      pos,
    input  logic [POS_W-1:0] cur,
    output logic [POS_W-1:0] nxt
);

    localparam logic signed [12:0] HALF = 13'(PADDLE_H / 2);
    localparam logic signed [12:0] LIM  = 13'(Y_MAX - PADDLE_H);
    localparam logic signed [12:0] STP  = 13'(STEP);

    logic signed [12:0] tgt;
    logic signed [12:0] cur_s;
    logic signed [12:0] diff;

    always_comb begin
        tgt = $signed({1'b0, pos}) - HALF;
        if (tgt[12]) begin
            tgt = '0;
        end else if (tgt > LIM) begin
            tgt = LIM;
        end
        cur_s = $signed(13'(cur));
        diff  = tgt - cur_s;
        if (diff > STP) begin
            nxt = POS_W'(cur_s + STP);
        end else if (diff < -STP) begin
            nxt = POS_W'(cur_s - STP);
        end else begin
            nxt = POS_W'(tgt);
        end
    end

endmodule

// File: rtl/paddle_ctl.sv
// Per-frame paddle position controller: mouse-driven player 1, AI or remote
// player 2, peer-link transmit pulse and remote timeout detection.
module paddle_ctl
    import vga_pkg::*;
#(
    parameter int PADDLE_H       = PADDLE_H_DEF,
    parameter int Y_MAX          = Y_MAX_DEF,
    parameter int STEP           = STEP_DEF,
    parameter int AI_STEP        = AI_STEP_DEF,
    parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF,
    parameter int POS_W          = POS_W_DEF
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic [1:0]       mode,
    input  logic [11:0]      mouse_ypos,
    input  logic [POS_W-1:0] ball_y,
    input  logic [POS_W-1:0] remote_pos,
    input  logic             remote_valid,
    output logic [POS_W-1:0] p1_y,
    output logic [POS_W-1:0] p2_y,
    output logic [POS_W-1:0] tx_pos,
    output logic             tx_valid,
    output logic             link_lost,
    output logic [1:0]       dbg_state
);

    localparam logic [POS_W-1:0] CENTRE = POS_W'((Y_MAX - PADDLE_H) / 2);
    localparam logic [POS_W-1:0] LIM    = POS_W'(Y_MAX - PADDLE_H);
    localparam int               CNT_W  = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0] TO     = CNT_W'(TIMEOUT_FRAMES);

    paddle_st_e       state;
    paddle_st_e       st_nxt;
    logic [POS_W-1:0] p1_nxt;
    logic [POS_W-1:0] p2_nxt;
    logic [POS_W-1:0] rem_q;
    logic             rem_pend;
    logic [POS_W-1:0] rem_src;
    logic [POS_W-1:0] rem_sat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             tick_d1;

    paddle_slew #(.PADDLE_H(PADDLE_H), .Y_MAX(Y_MAX), .STEP(STEP), .POS_W(POS_W)) u_p1_slew (
        .pos (mouse_ypos),
        .cur (p1_y),
        .nxt (p1_nxt)
    );

    paddle_slew #(.PADDLE_H(PADDLE_H), .Y_MAX(Y_MAX), .STEP(AI_STEP), .POS_W(POS_W)) u_p2_slew (
        .pos (12'(ball_y)),
        .cur (p2_y),
        .nxt (p2_nxt)
    );

    // Mode only matters at frame start; a value arriving with the tick wins over the latch.
    assign st_nxt    = frame_tick ? mode_to_state(mode) : state;
    assign rem_src   = remote_valid ? remote_pos : rem_q;
    assign rem_sat   = (rem_src > LIM) ? LIM : rem_src;
    assign cnt_inc   = (cnt == TO) ? TO : cnt + CNT_W'(1);
    assign dbg_state = state;

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            p1_y      <= CENTRE;
            p2_y      <= CENTRE;
            tx_pos    <= CENTRE;
            tx_valid  <= 1'b0;
            link_lost <= 1'b0;
            rem_q     <= '0;
            rem_pend  <= 1'b0;
            cnt       <= '0;
            tick_d1   <= 1'b0;
        end else begin
            state    <= st_nxt;
            tx_valid <= 1'b0;
            tick_d1  <= frame_tick && (st_nxt == ST_MULTI);

            if (remote_valid) begin
                rem_q    <= remote_pos;
                rem_pend <= 1'b1;
            end

            if (frame_tick) begin
                case (st_nxt)
                    ST_SINGLE: begin
                        p1_y <= p1_nxt;
                        p2_y <= p2_nxt;
                    end
                    ST_MULTI: begin
                        p1_y <= p1_nxt;
                        if (remote_valid || rem_pend) begin
                            p2_y     <= rem_sat;
                            rem_pend <= 1'b0;
                        end
                    end
                    default: begin
                        p1_y <= CENTRE;
                        p2_y <= CENTRE;
                    end
                endcase
            end

            // p1_y has settled one cycle after the tick, so it is sent then.
            if (tick_d1 && (state == ST_MULTI)) begin
                tx_valid <= 1'b1;
                tx_pos   <= p1_y;
            end

            if (st_nxt != ST_MULTI) begin
                cnt       <= '0;
                link_lost <= 1'b0;
                rem_pend  <= 1'b0;
            end else if (remote_valid) begin
                cnt       <= '0;
                link_lost <= 1'b0;
            end else if (frame_tick) begin
                cnt       <= cnt_inc;
                link_lost <= (cnt_inc == TO);
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed scoreboard bench for paddle_ctl at default geometry (CENTRE 320, limit 640).
`timescale 1ns/1ps
module tb_paddle_ctl;

    localparam int POS_W = 10;

    logic             clk65MHz     = 1'b0;
    logic             rst_n        = 1'b0;
    logic             frame_tick   = 1'b0;
    logic [1:0]       mode         = 2'd0;
    logic [11:0]      mouse_ypos   = 12'd0;
    logic [POS_W-1:0] ball_y       = '0;
    logic [POS_W-1:0] remote_pos   = '0;
    logic             remote_valid = 1'b0;
    logic [POS_W-1:0] p1_y;
    logic [POS_W-1:0] p2_y;
    logic [POS_W-1:0] tx_pos;
    logic             tx_valid;
    logic             link_lost;
    logic [1:0]       dbg_state;

    paddle_ctl dut (
        .clk65MHz     (clk65MHz),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .mode         (mode),
        .mouse_ypos   (mouse_ypos),
        .ball_y       (ball_y),
        .remote_pos   (remote_pos),
        .remote_valid (remote_valid),
        .p1_y         (p1_y),
        .p2_y         (p2_y),
        .tx_pos       (tx_pos),
        .tx_valid     (tx_valid),
        .link_lost    (link_lost),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk65MHz = ~clk65MHz;

    // ---------------- scoreboard ----------------
    typedef struct {
        int               id;
        logic [POS_W-1:0] p1;
        logic [POS_W-1:0] p2;
        logic             ll;
        logic             txv;
        logic [1:0]       st;
        bit               chk_txp;
        logic [POS_W-1:0] txp;
    } snap_t;

    snap_t            snap_q[$];
    logic [POS_W-1:0] exp_q[$];
    int               checks  = 0;
    int               errors  = 0;
    int               snap_id = 0;

    task automatic check_val(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (snap %0d): got %0d expected %0d at %0t", name, id, act, exp, $time);
        end
    endtask

    always @(negedge clk65MHz) begin
        snap_t s;
        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            check_val("p1_y", s.id, int'(p1_y), int'(s.p1));
            check_val("p2_y", s.id, int'(p2_y), int'(s.p2));
            check_val("link_lost", s.id, int'(link_lost), int'(s.ll));
            check_val("tx_valid", s.id, int'(tx_valid), int'(s.txv));
            check_val("state", s.id, int'(dbg_state), int'(s.st));
            if (s.chk_txp) check_val("tx_pos_reset", s.id, int'(tx_pos), int'(s.txp));
        end
        if (tx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: tx_valid=1 tx_pos=%0d with no pending expectation at %0t",
                         tx_pos, $time);
            end else begin
                check_val("tx_pos", -1, int'(tx_pos), int'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_snap(input int p1, input int p2, input bit ll, input bit txv, input int st);
        snap_t s;
        snap_id++;
        s.id = snap_id; s.p1 = POS_W'(p1); s.p2 = POS_W'(p2); s.ll = ll; s.txv = txv;
        s.st = 2'(st); s.chk_txp = 1'b0; s.txp = '0;
        snap_q.push_back(s);
    endtask

    task automatic push_reset_snap();
        snap_t s;
        snap_id++;
        s.id = snap_id; s.p1 = 10'd320; s.p2 = 10'd320; s.ll = 1'b0; s.txv = 1'b0;
        s.st = 2'd0; s.chk_txp = 1'b1; s.txp = 10'd320;
        snap_q.push_back(s);
    endtask

    task automatic cycle();
        @(posedge clk65MHz);
        #1;
    endtask

    // One frame tick (optionally with a coincident remote update), then three cycles of expectations.
    task automatic tick_chk(input int p1, input int p2, input bit ll, input int st,
                            input bit rv, input int rpos);
        cycle();
        frame_tick = 1'b1;
        if (rv) begin
            remote_valid = 1'b1;
            remote_pos   = POS_W'(rpos);
        end
        cycle();
        frame_tick   = 1'b0;
        remote_valid = 1'b0;
        push_snap(p1, p2, ll, 1'b0, st);
        if (st == 2) exp_q.push_back(POS_W'(p1));
        cycle();
        push_snap(p1, p2, ll, st == 2, st);
        cycle();
        push_snap(p1, p2, ll, 1'b0, st);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) cycle();
        push_reset_snap();
        cycle();
        rst_n = 1'b1;
        cycle();
        push_snap(320, 320, 0, 0, 0);

        // Single player: p1 chases a far-bottom mouse then a near-top one.
        mode = 2'd1; mouse_ypos = 12'd1000; ball_y = 10'd384;
        for (int i = 1; i <= 45; i++) tick_chk((i <= 40) ? 320 + 8 * i : 640, 320, 0, 1, 0, 0);
        mouse_ypos = 12'd10;
        for (int i = 1; i <= 82; i++) tick_chk((i <= 80) ? 640 - 8 * i : 0, 320, 0, 1, 0, 0);

        // AI paddle follows the ball at the slower rate, then a sub-step move.
        ball_y = 10'd0;
        for (int i = 1; i <= 82; i++) tick_chk(0, (i <= 80) ? 320 - 4 * i : 0, 0, 1, 0, 0);
        ball_y = 10'd66;
        tick_chk(0, 2, 0, 1, 0, 0);

        // Multiplayer: remote value held off until the tick, clamped to 640.
        mode = 2'd2; mouse_ypos = 12'd200;
        tick_chk(8, 2, 0, 2, 0, 0);
        cycle();
        remote_valid = 1'b1; remote_pos = 10'd900;
        cycle();
        remote_valid = 1'b0;
        push_snap(8, 2, 0, 0, 2);
        cycle();
        push_snap(8, 2, 0, 0, 2);
        tick_chk(16, 640, 0, 2, 0, 0);

        // Remote update coinciding with the tick uses the new value.
        tick_chk(24, 100, 0, 2, 1, 100);

        // No updates: link lost after the 4th tick, stays lost, cleared by remote_valid.
        tick_chk(32, 100, 0, 2, 0, 0);
        tick_chk(40, 100, 0, 2, 0, 0);
        tick_chk(48, 100, 0, 2, 0, 0);
        tick_chk(56, 100, 1, 2, 0, 0);
        tick_chk(64, 100, 1, 2, 0, 0);
        cycle();
        remote_valid = 1'b1; remote_pos = 10'd50;
        push_snap(64, 100, 1, 0, 2);
        cycle();
        remote_valid = 1'b0;
        push_snap(64, 100, 0, 0, 2);
        tick_chk(72, 50, 0, 2, 0, 0);

        // Mid-frame switch to idle waits for the tick.
        cycle();
        mode = 2'd0;
        cycle();
        push_snap(72, 50, 0, 0, 2);
        tick_chk(320, 320, 0, 0, 0, 0);
        mode = 2'd1;
        tick_chk(312, 316, 0, 1, 0, 0);
        mode = 2'd3;
        tick_chk(320, 320, 0, 0, 0, 0);

        // Reset mid-frame drops a pending remote value.
        mode = 2'd2;
        tick_chk(312, 320, 0, 2, 0, 0);
        cycle();
        remote_valid = 1'b1; remote_pos = 10'd500;
        cycle();
        remote_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        push_reset_snap();
        cycle();
        rst_n = 1'b1;
        tick_chk(312, 320, 0, 2, 0, 0);

        repeat (4) cycle();
        checks++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("FAIL drain: tx expectations left %0d, snapshots left %0d, required 0 and 0",
                     exp_q.size(), snap_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: stimulus still running at %0t, required completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_ctl.md
PADDLE_CTL -- requirements
Module: paddle_ctl

Interface
REQ-001 The block SHALL have parameter PADDLE_H, default 128, meaning paddle height in pixels.
REQ-002 The block SHALL have parameter Y_MAX, default 768, meaning visible screen height in lines.
REQ-003 The block SHALL have parameter STEP, default 8, meaning max paddle movement per frame in pixels.
REQ-004 The block SHALL have parameter AI_STEP, default 4, meaning max AI paddle movement per frame in pixels.
REQ-005 The block SHALL have parameter TIMEOUT_FRAMES, default 4, meaning frames without a remote update before link loss.
REQ-006 The block SHALL have parameter POS_W, default 10, meaning position width in bits.
REQ-007 The block SHALL have port clk65MHz, input, 1, the single clock.
REQ-008 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-009 The block SHALL have port frame_tick, input, 1, one-cycle pulse at frame start.
REQ-010 The block SHALL have port mode, input, 2, game mode (IDLE, SINGLE, MULTI).
REQ-011 The block SHALL have port mouse_ypos, input, 12, local mouse Y.
REQ-012 The block SHALL have port ball_y, input, POS_W, ball Y for AI tracking.
REQ-013 The block SHALL have port remote_pos, input, POS_W, peer paddle Y.
REQ-014 The block SHALL have port remote_valid, input, 1, remote_pos qualifier (one-cycle pulse).
REQ-015 The block SHALL have port p1_y, output, POS_W, player-1 paddle top Y.
REQ-016 The block SHALL have port p2_y, output, POS_W, player-2 paddle top Y.
REQ-017 The block SHALL have port tx_pos, output, POS_W, local position for the peer link.
REQ-018 The block SHALL have port tx_valid, output, 1, tx_pos qualifier pulse.
REQ-019 The block SHALL have port link_lost, output, 1, remote peer timeout flag.

Function
REQ-020 The block SHALL use a state machine with states ST_IDLE, ST_SINGLE and ST_MULTI; mode is sampled only on frame_tick, so a mid-frame mode change takes effect at the next tick.
REQ-021 On any transition into ST_IDLE, the block SHALL set p1_y and p2_y to CENTRE = (Y_MAX-PADDLE_H)/2 in the cycle after the tick, then hold them.
REQ-022 In ST_SINGLE and ST_MULTI, the p1 target SHALL be mouse_ypos-PADDLE_H/2, saturated to 0 when negative and to Y_MAX-PADDLE_H when larger; all arithmetic SHALL be 13-bit signed before truncation.
REQ-023 On each frame_tick, p1_y SHALL move toward its target by min(|target-p1_y|, STEP), updating in the cycle after the tick.
REQ-024 In ST_SINGLE, p2_y SHALL slew toward ball_y-PADDLE_H/2 (same saturation) by at most AI_STEP per tick.
REQ-025 In ST_MULTI, the block SHALL latch remote_pos on remote_valid and apply it to p2_y unslewed at the next frame_tick, saturated to Y_MAX-PADDLE_H.
REQ-026 If remote_valid and frame_tick coincide, the block SHALL use the newly arriving value.
REQ-027 In ST_MULTI, the block SHALL count frame_ticks since the last remote_valid and assert link_lost when the count reaches TIMEOUT_FRAMES, with p2_y holding; the count SHALL saturate, and remote_valid SHALL clear both the count and link_lost in the next cycle.
REQ-028 Outside ST_MULTI, link_lost SHALL be 0 and the count SHALL be cleared.
REQ-029 In ST_MULTI, tx_valid SHALL pulse for one cycle two cycles after frame_tick, with tx_pos equal to the updated p1_y; tx_valid SHALL be 0 in other states.
REQ-030 Outputs SHALL be registered; no output SHALL be combinational from inputs.

Reset
REQ-031 While rst_n is low, the block SHALL hold p1_y = p2_y = CENTRE, tx_pos = CENTRE, tx_valid = 0, link_lost = 0, state = ST_IDLE, the timeout counter and latched remote value cleared.
REQ-032 A reset asserted mid-frame SHALL discard any pending remote value or mode change.

Structure
REQ-033 The mode enum (IDLE=0, SINGLE=1, MULTI=2, value 3 treated as IDLE) and default geometry constants SHALL live in vga_pkg.
REQ-034 The block SHALL use one sub-module, paddle_slew, to perform target saturation plus step-limited movement, instantiated for p1 and for the p2 AI path.

Verification
REQ-035 The bench SHALL check reset: rst_n low -> p1_y = p2_y = 320, tx_valid = 0, link_lost = 0.
REQ-036 The bench SHALL check SINGLE mode with mouse_ypos = 1000: p1_y reads 328, 336, ... on successive ticks, reaches 640 after 40 ticks, then holds; mouse_ypos = 10 -> p1_y slews down to 0.
REQ-037 The bench SHALL check SINGLE mode with ball_y = 0 from 320: p2_y decreases by 4 per tick to 0.
REQ-038 The bench SHALL check MULTI mode with remote_valid and remote_pos = 900 mid-frame: p2_y stays unchanged until the tick, becomes 640 one cycle after it, and tx_valid pulses two cycles after the tick.
REQ-039 The bench SHALL check MULTI mode with no remote_valid for 4 ticks: link_lost = 1 after the 4th tick; a subsequent remote_valid clears it next cycle.
REQ-040 The bench SHALL check a mode change to IDLE mid-frame: there is no effect before the tick, and p1_y = p2_y = 320 one cycle after the tick.
